// File: rtl/fft_input_loader_if.sv
// Sample stream handshake between a source and the FFT input loader.
// The source drives valid/data/last and the loader returns ready.
interface fft_input_loader_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     in_last;

  modport master (output in_valid, output in_re, output in_im, output in_last, input in_ready);
  modport slave  (input in_valid, input in_re, input in_im, input in_last, output in_ready);
endinterface

// File: rtl/fft_input_loader.sv
// FFT input sequencer: accepts one complex sample per handshake, writes it to
// the engine input buffer at its bit-reversed index, pulses frame_ready when
// a full frame is stored, then holds off the source until proc_done.
module fft_input_loader #(
  parameter int N_LOG2 = 6,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fft_input_loader_if.slave        s_in,
  output logic                     o_wr_en,
  output logic [N_LOG2-1:0]        o_wr_addr,
  output logic signed [DATA_W-1:0] o_wr_re,
  output logic signed [DATA_W-1:0] o_wr_im,
  output logic [N_LOG2-1:0]        o_sample_cnt,
  output logic                     o_frame_ready,
  input  logic                     i_proc_done,
  output logic                     o_frame_err
);

  localparam logic [1:0] S_FILL    = 2'd0;
  localparam logic [1:0] S_HANDOFF = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;

  logic [1:0]               r_state;
  logic [N_LOG2-1:0]        r_cnt;
  logic                     r_frame_ready;
  logic                     r_frame_err;
  logic                     r_vld_p1;
  logic [N_LOG2-1:0]        r_wr_addr_p1;
  logic signed [DATA_W-1:0] r_wr_re_p1;
  logic signed [DATA_W-1:0] r_wr_im_p1;

  logic w_fill;
  logic w_accept;
  logic w_at_end;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  // ready is a pure state decode so it never combinationally follows valid
  assign w_fill         = (r_state == S_FILL);
  assign s_in.in_ready  = w_fill;
  assign w_accept       = s_in.in_valid & w_fill;
  assign w_at_end       = (r_cnt == LAST_IDX);

  assign o_wr_en        = r_vld_p1;
  assign o_wr_addr      = r_wr_addr_p1;
  assign o_wr_re        = r_wr_re_p1;
  assign o_wr_im        = r_wr_im_p1;
  assign o_sample_cnt   = r_cnt;
  assign o_frame_ready  = r_frame_ready;
  assign o_frame_err    = r_frame_err;

  // Frame sequencing: sample counter, FILL/HANDOFF/WAIT state, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_cnt         <= '0;
      r_frame_ready <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_ready <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (w_at_end) begin
              r_state <= S_HANDOFF;
              r_cnt   <= '0;
              if (!s_in.in_last) r_frame_err <= 1'b1;
            end else if (s_in.in_last) begin
              // early last: sample is written, the partial frame is dropped
              r_cnt       <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HANDOFF: begin
          // last write is visible now; frame_ready lands on the first WAIT cycle
          r_state       <= S_WAIT;
          r_frame_ready <= 1'b1;
        end
        S_WAIT: begin
          if (i_proc_done) r_state <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // p0 -> p1: accepted sample becomes a buffer write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_re_p1   <= '0;
      r_wr_im_p1   <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_wr_addr_p1 <= bitrev(r_cnt);
        r_wr_re_p1   <= s_in.in_re;
        r_wr_im_p1   <= s_in.in_im;
      end
    end
  end

endmodule
